// File: rtl/full_adder.sv
// full_adder: parameterizable ripple-carry adder built from one-bit cells.
// Combinational Sum/Carry of A + B + Cin plus group propagate/generate,
// and a registered copy of the result qualified by in_valid.
//
// Ports:
//   clk       rising-edge clock for the registered outputs
//   rst_n     asynchronous active-low reset (clears registered outputs)
//   A, B      WIDTH-bit unsigned operands
//   Cin       carry-in
//   in_valid  capture enable for the output register
//   Sum       combinational (A + B + Cin)[WIDTH-1:0]
//   Carry     combinational carry-out
//   P         group propagate, &(A ^ B)
//   G         group generate, carry-out with a zero carry-in
//   Sum_q     registered Sum
//   Carry_q   registered Carry
//   out_valid registered valid, high the cycle after an in_valid capture
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             P,
  output logic             G,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Carry_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_prop;   // per-bit propagate A ^ B
  logic [WIDTH-1:0] w_gen;    // per-bit generate A & B
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_c;      // carry chain seeded by Cin
  logic [WIDTH:0]   w_g;      // same chain seeded by 0, yields group generate

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  assign w_prop = A ^ B;
  assign w_gen  = A & B;
  assign w_c[0] = Cin;
  assign w_g[0] = 1'b0;

  // One full-adder cell per bit; the second chain shares the cell terms.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_sum[i] = w_prop[i] ^ w_c[i];
    assign w_c[i+1] = w_gen[i] | (w_c[i] & w_prop[i]);
    assign w_g[i+1] = w_gen[i] | (w_g[i] & w_prop[i]);
  end

  assign Sum   = w_sum;
  assign Carry = w_c[WIDTH];
  assign P     = &w_prop;
  assign G     = w_g[WIDTH];

  // Result register: captures on in_valid, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_c[WIDTH];
      end
    end
  end

  assign Sum_q     = r_sum;
  assign Carry_q   = r_carry;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1, 8 and 16.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=1 instance
  logic [0:0] a1, b1, s1, sq1;
  logic cin1, v1, c1, p1, g1, cq1, ov1;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, sq8;
  logic cin8, v8, c8, p8, g8, cq8, ov8;
  // WIDTH=16 instance
  logic [15:0] a16, b16, s16, sq16;
  logic cin16, v16, c16, p16, g16, cq16, ov16;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .in_valid(v1),
    .Sum(s1), .Carry(c1), .P(p1), .G(g1),
    .Sum_q(sq1), .Carry_q(cq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(v8),
    .Sum(s8), .Carry(c8), .P(p8), .G(g8),
    .Sum_q(sq8), .Carry_q(cq8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .in_valid(v16),
    .Sum(s16), .Carry(c16), .P(p16), .G(g16),
    .Sum_q(sq16), .Carry_q(cq16), .out_valid(ov16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed WIDTH=8 vector: explicit Sum/Carry, P/G from arithmetic reference.
  task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] exp_s, input logic exp_c);
    logic [8:0] ab;
    a8 = a; b8 = b; cin8 = c;
    #1;
    ab = 9'(a) + 9'(b);
    check("w8 sum", 32'(s8), 32'(exp_s));
    check("w8 carry", 32'(c8), 32'(exp_c));
    check("w8 model", 32'({c8, s8}), 32'(ab + 9'(c)));
    // All bits differ exactly when A+B is all-ones with no carry.
    check("w8 P", 32'(p8), 32'(ab == 9'h0FF));
    check("w8 G", 32'(g8), 32'(ab > 9'h0FF));
  endtask

  initial begin
    logic [2:0]  t;
    logic [16:0] ab16;
    logic [16:0] tot16;
    logic [15:0] m_sum;
    logic        m_carry;
    logic        m_valid;

    rst_n = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0; v1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; v8 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0; v16 = 1'b0;

    #12;
    check("rst sq1", 32'(sq1), 32'd0);
    check("rst cq1", 32'(cq1), 32'd0);
    check("rst ov1", 32'(ov1), 32'd0);
    check("rst sq8", 32'(sq8), 32'd0);
    check("rst cq8", 32'(cq8), 32'd0);
    check("rst ov8", 32'(ov8), 32'd0);
    check("rst sq16", 32'(sq16), 32'd0);
    check("rst cq16", 32'(cq16), 32'd0);
    check("rst ov16", 32'(ov16), 32'd0);
    // Combinational path tracks inputs during reset.
    check("rst s8 zero", 32'(s8), 32'd0);
    check("rst c8 zero", 32'(c8), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      a1 = t[2]; b1 = t[1]; cin1 = t[0];
      #5;
      check("w1 sumcarry", 32'({c1, s1}), 32'(2'(t[2]) + 2'(t[1]) + 2'(t[0])));
      check("w1 P", 32'(p1), 32'(t[2] != t[1]));
      check("w1 G", 32'(g1), 32'(t[2] & t[1]));
    end

    // WIDTH=8 directed boundaries.
    apply8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    apply8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    apply8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
    apply8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
    apply8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    apply8(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1);

    // Registered path: capture, then hold.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4; cin8 = 1'b1; v8 = 1'b1;
    @(posedge clk); #1;
    check("reg sum_q", 32'(sq8), 32'd8);
    check("reg carry_q", 32'(cq8), 32'd0);
    check("reg valid", 32'(ov8), 32'd1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h10;
    @(posedge clk); #1;
    check("hold sum_q", 32'(sq8), 32'd8);
    check("hold valid", 32'(ov8), 32'd0);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst sum_q", 32'(sq8), 32'd0);
    check("arst carry_q", 32'(cq8), 32'd0);
    check("arst valid", 32'(ov8), 32'd0);
    check("arst sum live", 32'(s8), 32'h15);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=16 random against arithmetic reference with a register model.
    m_sum = '0; m_carry = 1'b0; m_valid = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); v16 = 1'($urandom);
      #1;
      ab16 = 17'(a16) + 17'(b16);
      tot16 = ab16 + 17'(cin16);
      check("r16 sumcarry", 32'({c16, s16}), 32'(tot16));
      check("r16 P", 32'(p16), 32'(ab16 == 17'h0FFFF));
      check("r16 G", 32'(g16), 32'(ab16 > 17'h0FFFF));
      check("r16 inv", 32'(c16), 32'(g16 | (p16 & cin16)));
      if (v16) begin
        m_sum = tot16[15:0];
        m_carry = tot16[16];
      end
      m_valid = v16;
      @(posedge clk); #1;
      check("r16 sum_q", 32'(sq16), 32'(m_sum));
      check("r16 carry_q", 32'(cq16), 32'(m_carry));
      check("r16 valid", 32'(ov16), 32'(m_valid));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
